// File: rtl/block_mult_scheduler.sv
// Tile/K-block sequencing controller for the block matrix multiplier.
// Drives load, systolic and accumulate strobes; carries no matrix data.
module block_mult_scheduler #(
    parameter int K_W = 4,
    parameter int T_W = 8
) (
    input  logic           clock_i,
    input  logic           reset_i,
    input  logic           start_i,
    input  logic           abort_i,
    input  logic [T_W-1:0] num_tiles_i,
    input  logic [K_W-1:0] num_k_i,
    output logic           load_req_o,
    input  logic           load_ack_i,
    output logic [T_W-1:0] load_tile_idx_o,
    output logic [K_W-1:0] load_k_idx_o,
    output logic           sys_start_o,
    input  logic           sys_done_i,
    output logic           acc_clear_o,
    output logic           acc_en_o,
    input  logic           acc_done_i,
    output logic           tile_valid_o,
    input  logic           tile_ready_i,
    output logic [T_W-1:0] tile_idx_o,
    output logic           busy_o,
    output logic           done_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_ACC,
        S_OUT
    } state_t;

    state_t         state_q;
    logic [T_W-1:0] tiles_q;
    logic [K_W-1:0] nk_q;
    logic [T_W-1:0] tile_q;
    logic [K_W-1:0] k_q;
    logic           load_req_q;
    logic           sys_start_q;
    logic           acc_clear_q;
    logic           acc_en_q;
    logic           tile_valid_q;
    logic           busy_q;
    logic           done_q;

    logic           last_k_d;
    logic           last_tile_d;
    logic [K_W-1:0] k_inc_d;
    logic [T_W-1:0] tile_inc_d;
    logic           job_ok_d;

    always_comb begin
        last_k_d    = (k_q == nk_q - 1'b1);
        last_tile_d = (tile_q == tiles_q - 1'b1);
        k_inc_d     = k_q + 1'b1;
        tile_inc_d  = tile_q + 1'b1;
        job_ok_d    = (num_tiles_i != '0) && (num_k_i != '0);
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state_q      <= S_IDLE;
            tiles_q      <= '0;
            nk_q         <= '0;
            tile_q       <= '0;
            k_q          <= '0;
            load_req_q   <= 1'b0;
            sys_start_q  <= 1'b0;
            acc_clear_q  <= 1'b0;
            acc_en_q     <= 1'b0;
            tile_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            sys_start_q <= 1'b0;
            acc_en_q    <= 1'b0;
            acc_clear_q <= 1'b0;
            done_q      <= 1'b0;
            // abort beats any handshake landing in the same cycle
            if (abort_i && (state_q != S_IDLE)) begin
                state_q      <= S_IDLE;
                tile_q       <= '0;
                k_q          <= '0;
                load_req_q   <= 1'b0;
                tile_valid_q <= 1'b0;
                busy_q       <= 1'b0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (start_i && job_ok_d) begin
                            tiles_q     <= num_tiles_i;
                            nk_q        <= num_k_i;
                            tile_q      <= '0;
                            k_q         <= '0;
                            acc_clear_q <= 1'b1;
                            load_req_q  <= 1'b1;
                            busy_q      <= 1'b1;
                            state_q     <= S_LOAD;
                        end else if (start_i) begin
                            done_q <= 1'b1;
                        end
                    end
                    S_LOAD: begin
                        if (load_ack_i) begin
                            load_req_q  <= 1'b0;
                            sys_start_q <= 1'b1;
                            state_q     <= S_RUN;
                        end
                    end
                    S_RUN: begin
                        if (sys_done_i) begin
                            acc_en_q <= 1'b1;
                            state_q  <= S_ACC;
                        end
                    end
                    S_ACC: begin
                        if (acc_done_i && last_k_d) begin
                            tile_valid_q <= 1'b1;
                            state_q      <= S_OUT;
                        end else if (acc_done_i) begin
                            k_q        <= k_inc_d;
                            load_req_q <= 1'b1;
                            state_q    <= S_LOAD;
                        end
                    end
                    S_OUT: begin
                        if (tile_ready_i && last_tile_d) begin
                            tile_valid_q <= 1'b0;
                            done_q       <= 1'b1;
                            busy_q       <= 1'b0;
                            tile_q       <= '0;
                            k_q          <= '0;
                            state_q      <= S_IDLE;
                        end else if (tile_ready_i) begin
                            tile_valid_q <= 1'b0;
                            tile_q       <= tile_inc_d;
                            k_q          <= '0;
                            acc_clear_q  <= 1'b1;
                            load_req_q   <= 1'b1;
                            state_q      <= S_LOAD;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign load_req_o      = load_req_q;
    assign load_tile_idx_o = tile_q;
    assign load_k_idx_o    = k_q;
    assign sys_start_o     = sys_start_q;
    assign acc_clear_o     = acc_clear_q;
    assign acc_en_o        = acc_en_q;
    assign tile_valid_o    = tile_valid_q;
    assign tile_idx_o      = tile_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;

endmodule

// File: tb/tb_block_mult_scheduler.sv
// Self-checking bench for block_mult_scheduler: directed scenarios
// with literal expectations plus a randomized run against a job model.
module tb_block_mult_scheduler;

    localparam int K_W = 4;
    localparam int T_W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n, start, abort, la, sd, ad, tr;
    logic [T_W-1:0] nt;
    logic [K_W-1:0] nk;
    logic           lr, ss, clr, acc, tv, busy, done;
    logic [T_W-1:0] lti, ti;
    logic [K_W-1:0] lki;

    block_mult_scheduler #(.K_W(K_W), .T_W(T_W)) dut (
        .clock_i        (clk),
        .reset_i        (rst_n),
        .start_i        (start),
        .abort_i        (abort),
        .num_tiles_i    (nt),
        .num_k_i        (nk),
        .load_req_o     (lr),
        .load_ack_i     (la),
        .load_tile_idx_o(lti),
        .load_k_idx_o   (lki),
        .sys_start_o    (ss),
        .sys_done_i     (sd),
        .acc_clear_o    (clr),
        .acc_en_o       (acc),
        .acc_done_i     (ad),
        .tile_valid_o   (tv),
        .tile_ready_i   (tr),
        .tile_idx_o     (ti),
        .busy_o         (busy),
        .done_o         (done)
    );

    int total = 0;
    int bad = 0;

    // job model: what the controller is waiting for, plus position in the job
    // 0 idle, 1 load_ack, 2 sys_done, 3 acc_done, 4 tile_ready
    int m_wait = 0;
    int m_tile = 0;
    int m_k = 0;
    int m_nt = 0;
    int m_nk = 0;
    bit e_ss, e_acc, e_clr, e_done;

    int c_ss, c_acc, c_clr, c_done, c_lr, c_tv;
    bit prev_lr, prev_tv;
    int kq[$];
    int tq[$];

    function automatic void chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic model_update();
        e_ss = 0; e_acc = 0; e_clr = 0; e_done = 0;
        if (!rst_n) begin
            m_wait = 0; m_tile = 0; m_k = 0;
        end else if (m_wait != 0 && abort) begin
            m_wait = 0; m_tile = 0; m_k = 0;
        end else begin
            case (m_wait)
                0: if (start) begin
                    if (nt != 0 && nk != 0) begin
                        m_nt = int'(nt); m_nk = int'(nk);
                        m_tile = 0; m_k = 0; e_clr = 1; m_wait = 1;
                    end else e_done = 1;
                end
                1: if (la) begin e_ss = 1; m_wait = 2; end
                2: if (sd) begin e_acc = 1; m_wait = 3; end
                3: if (ad) begin
                    if (m_k == m_nk - 1) m_wait = 4;
                    else begin m_k++; m_wait = 1; end
                end
                4: if (tr) begin
                    if (m_tile == m_nt - 1) begin
                        e_done = 1; m_wait = 0; m_tile = 0; m_k = 0;
                    end else begin
                        m_tile++; m_k = 0; e_clr = 1; m_wait = 1;
                    end
                end
                default: m_wait = 0;
            endcase
        end
    endtask

    task automatic compare();
        chk("cyc_load_req", int'(lr), int'(m_wait == 1));
        chk("cyc_tile_valid", int'(tv), int'(m_wait == 4));
        chk("cyc_busy", int'(busy), int'(m_wait != 0));
        chk("cyc_sys_start", int'(ss), int'(e_ss));
        chk("cyc_acc_en", int'(acc), int'(e_acc));
        chk("cyc_acc_clear", int'(clr), int'(e_clr));
        chk("cyc_done", int'(done), int'(e_done));
        if (m_wait == 1) begin
            chk("cyc_load_tile_idx", int'(lti), m_tile);
            chk("cyc_load_k_idx", int'(lki), m_k);
        end
        if (m_wait != 0) chk("cyc_tile_idx", int'(ti), m_tile);
        c_ss += int'(ss); c_acc += int'(acc); c_clr += int'(clr);
        c_done += int'(done); c_lr += int'(lr); c_tv += int'(tv);
        if (lr && !prev_lr) kq.push_back(int'(lki));
        if (tv && !prev_tv) tq.push_back(int'(ti));
        prev_lr = lr; prev_tv = tv;
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        compare();
    endtask

    task automatic clear_inputs();
        start = 0; abort = 0; la = 0; sd = 0; ad = 0; tr = 0;
    endtask

    task automatic reset_counts();
        c_ss = 0; c_acc = 0; c_clr = 0; c_done = 0; c_lr = 0; c_tv = 0;
        kq.delete(); tq.delete();
    endtask

    // reactive responder: answers each strobe on the next edge
    task automatic drain(input int rdy_dly, input int budget, output int n);
        int wtv;
        bit ok;
        wtv = 0; n = 0; ok = 0;
        while (n < budget) begin
            if (done) begin ok = 1; break; end
            la = lr; sd = ss; ad = acc;
            if (tv) begin wtv++; tr = (wtv >= rdy_dly); end
            else begin wtv = 0; tr = 0; end
            step();
            n++;
        end
        clear_inputs();
        if (!ok) chk("job_timeout", 0, 1);
    endtask

    task automatic run_job(input int tiles, input int ks, input int rdy_dly, output int n);
        nt = T_W'(tiles); nk = K_W'(ks); start = 1;
        step();
        start = 0;
        drain(rdy_dly, 400, n);
    endtask

    initial begin
        int n;
        clear_inputs();
        nt = '0; nk = '0; rst_n = 0;
        prev_lr = 0; prev_tv = 0;
        reset_counts();
        step(); step();
        chk("reset_busy", int'(busy), 0);
        chk("reset_outs", int'({lr, ss, clr, acc, tv, done}), 0);
        rst_n = 1;
        step();

        // reset held 3 cycles mid-RUN
        nt = 8'd2; nk = 4'd2; start = 1; step(); start = 0;
        la = 1; step(); la = 0;
        rst_n = 0;
        repeat (3) begin
            step();
            chk("rst_mid_run_outs", int'({lr, ss, clr, acc, tv, busy, done}), 0);
            chk("rst_mid_run_idx", int'({lti, lki, ti}), 0);
        end
        rst_n = 1; nt = 8'd1; nk = 4'd1; start = 1;
        step(); start = 0;
        chk("lr_after_start", int'(lr), 1);
        drain(1, 100, n);

        // one tile, two K blocks, immediate responses
        reset_counts();
        run_job(1, 2, 1, n);
        chk("b_cycles", n, 7);
        chk("b_acc_clear", c_clr, 1);
        chk("b_sys_start", c_ss, 2);
        chk("b_acc_en", c_acc, 2);
        chk("b_done", c_done, 1);
        chk("b_kq_size", kq.size(), 2);
        if (kq.size() == 2) begin
            chk("b_k0", kq[0], 0);
            chk("b_k1", kq[1], 1);
        end
        chk("b_tq_size", tq.size(), 1);
        step();

        // three tiles, tile_ready after 5 cycles of tile_valid
        reset_counts();
        run_job(3, 1, 5, n);
        chk("c_tv_cycles", c_tv, 15);
        chk("c_acc_clear", c_clr, 3);
        chk("c_done", c_done, 1);
        chk("c_tq_size", tq.size(), 3);
        if (tq.size() == 3) begin
            chk("c_t0", tq[0], 0);
            chk("c_t1", tq[1], 1);
            chk("c_t2", tq[2], 2);
        end
        step();

        // stray inputs and start while busy
        reset_counts();
        nt = 8'd1; nk = 4'd1; start = 1; step();
        nt = 8'd3; sd = 1; step();
        start = 0; sd = 0;
        chk("s_lr_held", int'(lr), 1);
        chk("s_no_acc", c_acc, 0);
        la = 1; step(); la = 0;
        ad = 1; step(); ad = 0;
        chk("s_run_acc", int'(acc), 0);
        chk("s_run_busy", int'(busy), 1);
        chk("s_run_lr", int'(lr), 0);
        sd = 1; step(); sd = 0;
        chk("s_acc_en", int'(acc), 1);
        drain(1, 100, n);
        chk("s_done", c_done, 1);
        chk("s_tiles", tq.size(), 1);
        step();

        // abort in ACC together with acc_done
        reset_counts();
        nt = 8'd2; nk = 4'd1; start = 1; step(); start = 0;
        la = 1; step(); la = 0;
        sd = 1; step(); sd = 0;
        abort = 1; ad = 1; step(); abort = 0; ad = 0;
        chk("a_busy", int'(busy), 0);
        chk("a_tv", int'(tv), 0);
        repeat (3) step();
        chk("a_no_tv", c_tv, 0);
        chk("a_no_done", c_done, 0);
        reset_counts();
        run_job(2, 1, 1, n);
        chk("a_rerun_tiles", tq.size(), 2);
        if (tq.size() > 0) chk("a_rerun_t0", tq[0], 0);
        chk("a_rerun_done", c_done, 1);
        step();

        // zero counts
        reset_counts();
        nt = 8'd0; nk = 4'd3; start = 1; step(); start = 0;
        chk("z_nt_done", int'(done), 1);
        chk("z_nt_busy", int'(busy), 0);
        step();
        chk("z_nt_done_off", int'(done), 0);
        nt = 8'd2; nk = 4'd0; start = 1; step(); start = 0;
        chk("z_nk_done", int'(done), 1);
        chk("z_nk_busy", int'(busy), 0);
        step();
        chk("z_no_lr", c_lr, 0);

        // randomized traffic
        repeat (3000) begin
            rst_n = ($urandom % 200 != 0);
            start = ($urandom % 8 == 0);
            abort = ($urandom % 60 == 0);
            nt = T_W'($urandom % 4);
            nk = K_W'($urandom % 4);
            la = lr ? ($urandom % 2 == 0) : ($urandom % 10 == 0);
            sd = ($urandom % 3 == 0);
            ad = ($urandom % 3 == 0);
            tr = tv ? ($urandom % 3 == 0) : ($urandom % 10 == 0);
            step();
        end
        clear_inputs();
        rst_n = 1;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/block_mult_scheduler.md
# block_mult_scheduler

Sequencing controller for one output tile stream of the block matrix multiplier. For each output tile it walks the K partial-product blocks through the systolic array and the adder buffer. It then presents the accumulated tile to the writeback side, and repeats for every tile. It owns the systolic start, accumulate and clear strobes and the load/writeback handshakes; it carries no matrix data.

## Interface
- K_W, 4, width of K-block count and index
- T_W, 8, width of tile count and index
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low; sampled on clock
- start  in  1  job request; honoured only in IDLE
- abort  in  1  synchronous job kill; returns to IDLE
- num_tiles  in  T_W  output tiles in job; latched at start
- num_k  in  K_W  partial blocks per tile; latched at start
- load_req  out  1  request A/B block load; held until load_ack
- load_ack  in  1  load complete
- load_tile_idx  out  T_W  tile being loaded; valid with load_req
- load_k_idx  out  K_W  K block being loaded; valid with load_req
- sys_start  out  1  one-cycle systolic array start strobe
- sys_done  in  1  one-cycle systolic completion pulse
- acc_clear  out  1  one-cycle accumulator clear before tile's first block
- acc_en  out  1  one-cycle "add systolic result" strobe to adder buffer
- acc_done  in  1  adder buffer accumulation complete
- tile_valid  out  1  accumulated tile ready; held until tile_ready
- tile_ready  in  1  writeback accepts tile
- tile_idx  out  T_W  index of current tile
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle job-complete pulse

## Operation
- All outputs are registered. Reset (reset=0 at an edge) forces IDLE, zeroes both indices and drives every output 0. Reset wins over every other input.
- IDLE: start=1 with num_tiles≠0 and num_k≠0 latches the counts, sets tile_idx=0 and k_idx=0, pulses acc_clear, and enters LOAD. start with either count 0 pulses done and stays in IDLE.
- LOAD: load_req=1. On load_ack: drop load_req, pulse sys_start, go to RUN.
- RUN: wait for sys_done. On sys_done: pulse acc_en, go to ACC.
- ACC: wait for acc_done.
  - If k_idx = num_k−1: go to OUT.
  - Otherwise: k_idx+1, go to LOAD.
- OUT: tile_valid=1. On tile_ready:
  - If tile_idx = num_tiles−1: pulse done, go to IDLE.
  - Otherwise: tile_idx+1, k_idx=0, pulse acc_clear, go to LOAD.
- Input gating:
  - sys_done is ignored outside RUN.
  - acc_done is ignored outside ACC.
  - load_ack is ignored outside LOAD.
  - tile_ready is ignored outside OUT.
  - start is ignored while busy.
- abort=1 in any non-IDLE state returns to IDLE next cycle. Outputs drop to 0 and no done pulse is issued. abort has priority over a simultaneous handshake input.
- Counts are unsigned; the maximum job is (2^T_W−1) tiles × (2^K_W−1) blocks, and indices never wrap.

## Timing
- Event sampled at edge t produces its response at edge t+1:
  - start → load_req and acc_clear high.
  - load_ack → load_req low, sys_start high.
  - sys_done → acc_en high.
  - acc_done → load_req (next k) or tile_valid high.
  - tile_ready → tile_valid low, plus done or load_req/acc_clear high.
- acc_clear, sys_start, acc_en and done are exactly one cycle wide.
- load_req and tile_valid are levels that stay stable until their handshake.
- Minimum per block: 3 cycles (LOAD→RUN→ACC) with immediate ack/done inputs.
- Simultaneous load_ack in the same cycle as load_req's first asserted cycle is legal and accepted.
- load_tile_idx and load_k_idx hold while load_req is high. tile_idx is stable through OUT.

## Test plan
- Reset held low 3 cycles mid-RUN → every output 0, busy=0. Release with start, num_tiles=1, num_k=1 → load_req high the cycle after start.
- num_tiles=1, num_k=2, bench acks each strobe 1 cycle later:
  - Exactly 1 acc_clear.
  - load_k_idx 0 then 1.
  - 2 sys_start and 2 acc_en.
  - tile_valid with tile_idx=0, then done one cycle after tile_ready.
- num_tiles=3, num_k=1, tile_ready delayed 5 cycles each:
  - tile_valid held 5 cycles per tile.
  - tile_idx 0,1,2.
  - 3 acc_clear pulses.
  - Single done.
- Stray sys_done in LOAD and stray acc_done in RUN → ignored, no acc_en, state unchanged. start pulsed while busy → no effect.
- abort asserted in ACC together with acc_done → IDLE next cycle, no tile_valid, no done. A new start then runs normally from tile 0.
- start with num_tiles=0 (and separately num_k=0) → done pulse next cycle, no load_req, busy stays 0.
